// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding, op codes and counter sizing for the serial adder
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/serial_add_if.sv
// serial_add_if: operand/result handshakes of the serial adder
interface serial_add_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, op_sub, out_valid, out_ready, carry_out, overflow, zero, busy;
  logic [WIDTH-1:0] op_a, op_b, result;
  modport master(output in_valid, op_a, op_b, op_sub, out_ready,
                 input in_ready, out_valid, result, carry_out, overflow, zero, busy);
  modport slave(input in_valid, op_a, op_b, op_sub, out_ready,
                output in_ready, out_valid, result, carry_out, overflow, zero, busy);
endinterface

// File: rtl/serial_add_limb.sv
// serial_add_limb: combinational LIMB-bit adder with MSB taps for overflow detection
module serial_add_limb #(parameter int LIMB = 8) (
  input  logic [LIMB-1:0] a,
  input  logic [LIMB-1:0] b,
  input  logic            ci,
  output logic [LIMB-1:0] s,
  output logic            co,
  output logic            a_msb,
  output logic            b_msb,
  output logic            s_msb
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{LIMB{1'b0}}, ci};
  assign a_msb = a[LIMB-1];
  assign b_msb = b[LIMB-1];
  assign s_msb = s[LIMB-1];
endmodule

// File: rtl/serial_add_unit.sv
// serial_add_unit: multi-cycle add/sub processing LIMB bits per clock with a rippled carry register
module serial_add_unit import serial_add_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int LIMB  = 8
) (
  input logic clk,
  input logic rst,
  serial_add_if.slave bus
);
  localparam int NLIMB = WIDTH / LIMB;
  localparam int CW = cnt_w(NLIMB);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic carry, co, a_msb, b_msb, s_msb, last, accept;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_n;
  logic [LIMB-1:0] sum;
  serial_add_limb #(.LIMB(LIMB)) u_limb (
    .a(a_q[LIMB-1:0]), .b(b_q[LIMB-1:0]), .ci(carry),
    .s(sum), .co(co), .a_msb(a_msb), .b_msb(b_msb), .s_msb(s_msb)
  );
  assign last = cnt == CW'(NLIMB - 1);
  assign accept = bus.in_valid && bus.in_ready;
  // operands shift down so the active limb is always the low one; sums enter the accumulator from the top
  assign acc_n = (acc >> LIMB) | (WIDTH'(sum) << (WIDTH - LIMB));
  assign bus.in_ready = state == IDLE && !rst;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state != IDLE;
  always_comb begin
    state_n = state;
    if (state == IDLE && accept) state_n = RUN;
    else if (state == RUN && last) state_n = DONE;
    else if (state == DONE && bus.out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      carry <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      bus.result <= '0;
      bus.carry_out <= 1'b0;
      bus.overflow <= 1'b0;
      bus.zero <= 1'b0;
    end else if (accept) begin
      a_q <= bus.op_a;
      b_q <= bus.op_sub == OP_SUB ? ~bus.op_b : bus.op_b;
      carry <= bus.op_sub != OP_ADD;
      cnt <= '0;
    end else if (state == RUN) begin
      a_q <= a_q >> LIMB;
      b_q <= b_q >> LIMB;
      acc <= acc_n;
      carry <= co;
      cnt <= last ? '0 : cnt + CW'(1);
      if (last) begin
        bus.result <= acc_n;
        bus.carry_out <= co;
        bus.overflow <= (a_msb == b_msb) && (s_msb != a_msb);
        bus.zero <= acc_n == '0;
      end
    end
  end
endmodule

// File: tb/tb_serial_add_unit.sv
// tb_serial_add_unit: directed checks plus scoreboard for LIMB=8, and a LIMB sweep against an arithmetic model
module tb_serial_add_unit;
  logic clk = 0, rst = 1, rst_s = 1;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [31:0] corner [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  serial_add_if #(.WIDTH(32)) m();
  serial_add_unit #(.WIDTH(32), .LIMB(8)) dut(.clk(clk), .rst(rst), .bus(m));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  // {carry, overflow, zero, result} from unsigned/signed arithmetic on the operands
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    longint sa = longint'($signed(a)), sb = longint'($signed(b)), sr;
    logic [31:0] r;
    logic c, v;
    r = sub ? a - b : a + b;
    c = sub ? a >= b : ({1'b0, a} + {1'b0, b}) > 33'hFFFFFFFF;
    sr = sub ? sa - sb : sa + sb;
    v = sr > 64'sd2147483647 || sr < -64'sd2147483648;
    return {c, v, r == 32'h0, r};
  endfunction
  logic [34:0] sbq[$];
  int acc_t[$];
  logic prev_v = 0;
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      acc_t.delete();
      prev_v = 0;
    end else begin
      if (m.in_valid && m.in_ready) begin
        sbq.push_back(model(m.op_a, m.op_b, m.op_sub));
        acc_t.push_back(cyc + 1);
      end
      if (m.out_valid) begin
        if (sbq.size() == 0) chk("sb_unexpected_valid", m.out_valid, 0);
        else begin
          chk("sb_result", m.result, sbq[0][31:0]);
          chk("sb_flags", {m.carry_out, m.overflow, m.zero}, sbq[0][34:32]);
          if (!prev_v) chk("sb_latency", cyc - acc_t[0], 4);
          if (m.out_ready) begin
            void'(sbq.pop_front());
            void'(acc_t.pop_front());
          end
        end
      end
      prev_v = m.out_valid;
    end
  end
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s);
    m.op_a = a;
    m.op_b = b;
    m.op_sub = s;
    m.in_valid = 1;
  endtask
  task automatic wait_accept();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (m.in_ready) break;
    end
    chk("accept", m.in_ready, 1);
    @(posedge clk);
    #1 m.in_valid = 0;
  endtask
  task automatic wait_valid();
    for (int k = 0; k < 50 && !m.out_valid; k++) @(negedge clk);
    chk("out_valid", m.out_valid, 1);
  endtask
  task automatic check_out(input string n, input logic [31:0] r, input logic c, input logic v, input logic z);
    chk({n, "_result"}, m.result, r);
    chk({n, "_carry"}, m.carry_out, c);
    chk({n, "_overflow"}, m.overflow, v);
    chk({n, "_zero"}, m.zero, z);
  endtask
  task automatic op(input string n, input logic [31:0] a, input logic [31:0] b, input logic s,
                    input logic [31:0] r, input logic c, input logic v, input logic z);
    drive(a, b, s);
    wait_accept();
    wait_valid();
    check_out(n, r, c, v, z);
    @(posedge clk);
    #1;
  endtask
  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int L = g == 0 ? 1 : g == 1 ? 4 : 32;
    logic done = 0;
    serial_add_if #(.WIDTH(32)) s();
    serial_add_unit #(.WIDTH(32), .LIMB(L)) u(.clk(clk), .rst(rst_s), .bus(s));
    initial begin
      logic [31:0] a, b;
      logic sb;
      logic [34:0] e;
      int k;
      s.in_valid = 0; s.op_a = 0; s.op_b = 0; s.op_sub = 0; s.out_ready = 1;
      @(negedge clk);
      while (rst_s) @(negedge clk);
      for (int i = 0; i < 300; i++) begin
        a = i % 3 == 0 ? corner[$urandom_range(4)] : $urandom();
        b = i % 5 == 0 ? corner[$urandom_range(4)] : $urandom();
        sb = 1'($urandom_range(1));
        @(posedge clk);
        #1 s.op_a = a; s.op_b = b; s.op_sub = sb; s.in_valid = 1;
        @(negedge clk);
        chk("sw_in_ready", s.in_ready, 1);
        @(posedge clk);
        #1 s.in_valid = 0;
        k = 0;
        do begin
          @(posedge clk);
          k++;
          @(negedge clk);
        end while (!s.out_valid && k < 100);
        e = model(a, b, sb);
        chk("sw_latency", k, 32 / L);
        chk("sw_result", s.result, e[31:0]);
        chk("sw_flags", {s.carry_out, s.overflow, s.zero}, e[34:32]);
      end
      done = 1;
    end
  end
  initial begin
    m.in_valid = 0; m.op_a = 0; m.op_b = 0; m.op_sub = 0; m.out_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", m.in_ready, 0);
    chk("rst_out_valid", m.out_valid, 0);
    chk("rst_busy", m.busy, 0);
    chk("rst_result", {m.result, m.carry_out, m.overflow, m.zero}, 0);
    rst = 0;
    rst_s = 0;
    @(posedge clk);
    #1 chk("post_rst_in_ready", m.in_ready, 1);
    op("add_ff_1", 32'h000000FF, 32'h1, 0, 32'h00000100, 0, 0, 0);
    op("add_max_pos", 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 0, 1, 0);
    op("add_wrap", 32'hFFFFFFFF, 32'h1, 0, 32'h0, 1, 0, 1);
    op("sub_5_5", 32'h5, 32'h5, 1, 32'h0, 1, 0, 1);
    op("sub_3_5", 32'h3, 32'h5, 1, 32'hFFFFFFFE, 0, 0, 0);
    op("sub_min_1", 32'h80000000, 32'h1, 1, 32'h7FFFFFFF, 1, 1, 0);
    // backpressure: result held while a second request waits
    m.out_ready = 0;
    drive(32'h12345678, 32'h11111111, 0);
    wait_accept();
    wait_valid();
    @(posedge clk);
    #1 drive(32'hFFFF0000, 32'h0000FFFF, 1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", m.out_valid, 1);
      chk("bp_in_ready", m.in_ready, 0);
      check_out("bp_hold", 32'h23456789, 0, 0, 0);
    end
    @(posedge clk);
    #1 m.out_ready = 1;
    wait_accept();
    wait_valid();
    check_out("bp_second", 32'hFFFE0001, 1, 0, 0);
    @(posedge clk);
    #1;
    // reset in the middle of RUN
    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    wait_accept();
    @(negedge clk);
    chk("run_busy", m.busy, 1);
    chk("run_in_ready", m.in_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1;
    #1 chk("abort_out_valid", m.out_valid, 0);
    chk("abort_busy", m.busy, 0);
    chk("abort_in_ready", m.in_ready, 0);
    chk("abort_outputs", {m.result, m.carry_out, m.overflow, m.zero}, 0);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 0;
    @(posedge clk);
    #1 chk("abort_release_in_ready", m.in_ready, 1);
    op("fresh_1_1", 32'h1, 32'h1, 0, 32'h2, 0, 0, 0);
    for (int i = 0; i < 30000 && !(sw[0].done && sw[1].done && sw[2].done); i++) @(posedge clk);
    if (!(sw[0].done && sw[1].done && sw[2].done)) begin
      n_fail++;
      $display("FAIL sweep_timeout: sweep did not complete within cycle budget");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
